// File: rtl/fpu_div_seq.sv
// Sequential IEEE-754 single-precision divider, restoring radix-2 mantissa loop.
// Optional o_dbz flag port enabled by defining FPU_DIV_DBZ_FLAG_EN.
module fpu_div_seq #(
    parameter int SIZE_DATA = 32,
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_MAN  = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_32_a,
    input  logic [SIZE_DATA-1:0] i_32_b,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_32_div
`ifdef FPU_DIV_DBZ_FLAG_EN
    ,
    output logic                 o_dbz
`endif
);

    localparam int FW   = SIZE_MAN - 1;
    localparam int RW   = SIZE_MAN + 1;
    localparam int QW   = SIZE_MAN + 2;
    localparam int ITER = SIZE_MAN + 2;

    localparam logic [SIZE_EXP-1:0] EMAX = {SIZE_EXP{1'b1}};
    localparam logic [FW-1:0]       QNAN = {1'b1, {(FW-1){1'b0}}};
    localparam logic [4:0]          LAST = 5'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                 valid_q;
    logic [SIZE_DATA-1:0] res_q;
    logic                 sign_q;
    logic                 spec_q;
    logic [SIZE_EXP-1:0]  ea_q, eb_q;
    logic [SIZE_MAN-1:0]  mb_q;
    logic [RW-1:0]        rem_q;
    logic [QW-1:0]        q_q;
    logic [4:0]           cnt_q;

    // Operand fields and special-value classification
    logic                 sa, sb, s_in;
    logic [SIZE_EXP-1:0]  ea, eb;
    logic [FW-1:0]        fa, fb;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic is_nan, is_inf, is_zero, special;
    logic [SIZE_DATA-1:0] spec_res;

    assign sa = i_32_a[SIZE_DATA-1];
    assign sb = i_32_b[SIZE_DATA-1];
    assign ea = i_32_a[SIZE_DATA-2 -: SIZE_EXP];
    assign eb = i_32_b[SIZE_DATA-2 -: SIZE_EXP];
    assign fa = i_32_a[FW-1:0];
    assign fb = i_32_b[FW-1:0];
    assign s_in = sa ^ sb;

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EMAX) && (fa == '0);
    assign b_inf  = (eb == EMAX) && (fb == '0);
    assign a_nan  = (ea == EMAX) && (fa != '0);
    assign b_nan  = (eb == EMAX) && (fb != '0);

    assign is_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
    assign is_inf  = a_inf | b_zero;
    assign is_zero = a_zero | b_inf;
    assign special = is_nan | is_inf | is_zero;

    // Fixed encodings for special operands, NaN taking precedence
    always_comb begin
        spec_res = {s_in, {SIZE_EXP{1'b0}}, {FW{1'b0}}};
        if (is_nan)
            spec_res = {s_in, EMAX, QNAN};
        else if (is_inf)
            spec_res = {s_in, EMAX, {FW{1'b0}}};
    end

    // One restoring step; the difference fits SIZE_MAN bits whenever rem>=mb
    logic                ge;
    logic [SIZE_MAN-1:0] diff;
    logic [RW-1:0]       rem_nxt;
    logic [QW-1:0]       q_nxt;

    assign ge      = (rem_q >= {1'b0, mb_q});
    assign diff    = rem_q[SIZE_MAN-1:0] - mb_q;
    assign rem_nxt = ge ? {diff, 1'b0} : {rem_q[SIZE_MAN-1:0], 1'b0};
    assign q_nxt   = {q_q[QW-2:0], ge};

    // Normalise, round to nearest even and range-check the quotient
    logic [SIZE_MAN-1:0]  mant;
    logic                 g, st, inc, carry;
    logic [FW-1:0]        frac;
    logic signed [9:0]    e_base, e_fin;
    logic [SIZE_DATA-1:0] rnd_res;

    always_comb begin
        if (q_q[QW-1]) begin
            mant   = q_q[QW-1:2];
            g      = q_q[1];
            st     = q_q[0] | (rem_q != '0);
            e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
        end else begin
            mant   = q_q[QW-2:1];
            g      = q_q[0];
            st     = (rem_q != '0);
            e_base = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126;
        end
        inc   = g & (st | mant[0]);
        carry = inc & (&mant);
        frac  = mant[FW-1:0] + {{(FW-1){1'b0}}, inc};
        e_fin = carry ? e_base + 10'sd1 : e_base;
        if (e_fin >= 10'sd255)
            rnd_res = {sign_q, EMAX, {FW{1'b0}}};
        else if (e_fin <= 10'sd0)
            rnd_res = {sign_q, {SIZE_EXP{1'b0}}, {FW{1'b0}}};
        else
            rnd_res = {sign_q, e_fin[SIZE_EXP-1:0], frac};
    end

    // Next-state logic; specials pass through ROUND to align output timing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_valid) state_d = special ? ROUND : DIV;
            DIV:     if (cnt_q == LAST) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (valid_q && i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Datapath: operand capture, iteration, result and output valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            sign_q  <= 1'b0;
            spec_q  <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        sign_q <= s_in;
                        spec_q <= special;
                        ea_q   <= ea;
                        eb_q   <= eb;
                        mb_q   <= {1'b1, fb};
                        rem_q  <= {2'b01, fa};
                        q_q    <= '0;
                        cnt_q  <= '0;
                        if (special) res_q <= spec_res;
                    end
                end
                DIV: begin
                    rem_q <= rem_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND: begin
                    if (!spec_q) res_q <= rnd_res;
                end
                DONE: begin
                    if (!valid_q)
                        valid_q <= 1'b1;
                    else if (i_ready)
                        valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = valid_q;
    assign o_32_div = res_q;

`ifdef FPU_DIV_DBZ_FLAG_EN
    logic dbz_pend_q, dbz_q;

    // Divide-by-zero flag: latched at accept, shown with o_valid
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            if (state_q == IDLE && i_valid)
                dbz_pend_q <= b_zero & ~a_zero & ~a_inf & ~a_nan;
            if (state_q == DONE) begin
                if (!valid_q)
                    dbz_q <= dbz_pend_q;
                else if (i_ready)
                    dbz_q <= 1'b0;
            end
        end
    end

    assign o_dbz = dbz_q;
`endif

endmodule

// File: tb/tb_fpu_div_seq.sv
// Directed testbench for fpu_div_seq.
// Hand-computed quotients, latency, backpressure and mid-operation reset.
module tb_fpu_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic        ordy;
    logic [31:0] a, b;
    logic        ov;
    logic        irdy;
    logic [31:0] q;
`ifdef FPU_DIV_DBZ_FLAG_EN
    logic        dbz;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_div_seq dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (iv),
        .o_ready (ordy),
        .i_32_a  (a),
        .i_32_b  (b),
        .o_valid (ov),
        .i_ready (irdy),
        .o_32_div(q)
`ifdef FPU_DIV_DBZ_FLAG_EN
        ,
        .o_dbz   (dbz)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v);
        iv = 1'b1;
        a  = ta;
        b  = tb_v;
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        int k;
        lat = 0;
        k   = 0;
        while (lat == 0 && k < 60) begin
            @(posedge clk);
            #1;
            k++;
            if (ov) lat = k;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic release_out(input string tag);
        irdy = 1'b1;
        @(posedge clk);
        #1;
        irdy = 1'b0;
        chk({tag, ".vlo"}, {31'b0, ov}, 32'd0);
        chk({tag, ".rdy1"}, {31'b0, ordy}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [31:0] ta,
                       input logic [31:0] tb_v, input logic [31:0] ex,
                       input int lat, input bit exdbz);
        chk({tag, ".rdy0"}, {31'b0, ordy}, 32'd1);
        issue(ta, tb_v);
        wait_valid(tag, lat);
        chk({tag, ".q"}, q, ex);
`ifdef FPU_DIV_DBZ_FLAG_EN
        chk({tag, ".dbz"}, {31'b0, dbz}, {31'b0, exdbz});
`else
        if (exdbz) chk({tag, ".nodbz"}, q, ex);
`endif
        release_out(tag);
    endtask

    initial begin
        bit seen;
        rst  = 1'b1;
        iv   = 1'b0;
        irdy = 1'b0;
        a    = '0;
        b    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.valid", {31'b0, ov}, 32'd0);
        chk("rst.q", q, 32'd0);
        chk("rst.ready", {31'b0, ordy}, 32'd1);

        run("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 28, 1'b0);
        run("div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 1'b0);
        run("div15_15", 32'h3FC00000, 32'h3FC00000, 32'h3F800000, 28, 1'b0);
        run("divm6_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, 28, 1'b0);
        run("dbz",      32'h3F800000, 32'h00000000, 32'h7F800000, 2, 1'b1);
        run("zz",       32'h00000000, 32'h00000000, 32'h7FC00000, 2, 1'b0);
        run("fin_inf",  32'hC0000000, 32'h7F800000, 32'h80000000, 2, 1'b0);
        run("nan_a",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, 1'b0);
        run("inf_inf",  32'hFF800000, 32'h7F800000, 32'hFFC00000, 2, 1'b0);
        run("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 28, 1'b0);
        run("flush",    32'h00800000, 32'h40000000, 32'h00000000, 28, 1'b0);

        issue(32'h3F800000, 32'h40400000);
        wait_valid("bp", 28);
        for (int i = 0; i < 10; i++) begin
            iv = i[0];
            a  = $urandom;
            b  = $urandom;
            @(posedge clk);
            #1;
            chk("bp.q", q, 32'h3EAAAAAB);
            chk("bp.rdy", {31'b0, ordy}, 32'd0);
            chk("bp.valid", {31'b0, ov}, 32'd1);
        end
        iv = 1'b0;
        release_out("bp");

        issue(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst.valid", {31'b0, ov}, 32'd0);
        chk("mrst.ready", {31'b0, ordy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (ov) seen = 1'b1;
        end
        chk("mrst.noval", {31'b0, seen}, 32'd0);
        run("after_rst", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
